port_fifo_scheduler: RTL

PORT_FIFO_SCHEDULER -- requirements
Module: port_fifo_scheduler

---
 rtl/port_fifo_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/port_fifo_scheduler.sv
// Round-robin burst scheduler over NUM_PORTS queues in a shared FIFO RAM; grant-to-first-data = 2 cycles (IDLE, LOAD).
// Enqueue held off per queue when full; dequeue holds head data (VALID) while deq_ready_in is low.
module port_fifo_scheduler #(
  parameter int NUM_PORTS  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_BURST  = 8,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PW-1:0]        enq_port_in,
  input  logic                 enq_valid_in,
  output logic                 enq_ready_out,
  output logic [PW-1:0]        fifo_wrport_out,
  output logic                 fifo_wrreq_out,
  output logic [PW-1:0]        fifo_rdport_out,
  output logic                 fifo_rdreq_out,
  output logic                 deq_valid_out,
  input  logic                 deq_ready_in,
  output logic [PW-1:0]        deq_port_out,
  output logic [NUM_PORTS-1:0] nonempty_out
);

  typedef enum logic [1:0] {IDLE, LOAD, VALID} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q [NUM_PORTS];
  logic [CW-1:0]  count_d [NUM_PORTS];
  logic [PW-1:0]  cur_port;
  logic [PW-1:0]  rr_ptr;
  logic [BW-1:0]  burst_cnt;
  logic           grant_found;
  logic [PW-1:0]  grant_port;
  logic [PW-1:0]  cand;
  logic           pop;
  logic           last_entry;
  logic           burst_last;

  assign enq_ready_out   = (count_q[enq_port_in] != CW'(FIFO_DEPTH));
  assign fifo_wrreq_out  = enq_valid_in & enq_ready_out;
  assign fifo_wrport_out = enq_port_in;
  assign pop             = deq_valid_out & deq_ready_in;
  assign fifo_rdreq_out  = pop;
  assign fifo_rdport_out = cur_port;
  assign deq_port_out    = cur_port;

  // Simultaneous write and pop on the same queue cancel out.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      count_d[i] = count_q[i];
      if (fifo_wrreq_out && (enq_port_in == PW'(i)) &&
          !(pop && (cur_port == PW'(i)) && (count_q[i] != '0)))
        count_d[i] = count_q[i] + 1'b1;
      else if (pop && (cur_port == PW'(i)) && (count_q[i] != '0) &&
               !(fifo_wrreq_out && (enq_port_in == PW'(i))))
        count_d[i] = count_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PORTS; i++) count_q[i] <= '0;
      nonempty_out <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        count_q[i]      <= count_d[i];
        nonempty_out[i] <= (count_d[i] != '0);
      end
    end
  end

  // Search starts one past the last granted queue so every queue gets its turn.
  always_comb begin
    grant_found = 1'b0;
    grant_port  = rr_ptr;
    cand        = rr_ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (cand == PW'(NUM_PORTS - 1)) ? '0 : cand + 1'b1;
      if (!grant_found && nonempty_out[cand]) begin
        grant_found = 1'b1;
        grant_port  = cand;
      end
    end
  end

  // Exiting on the last entry keeps a same-cycle write from racing the prefetch read.
  assign last_entry = (count_q[cur_port] == CW'(1));
  assign burst_last = (burst_cnt == BW'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = LOAD;
      LOAD:    state_d = VALID;
      VALID:   if (pop && (last_entry || burst_last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    deq_valid_out = (state_q == VALID);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_port  <= '0;
      rr_ptr    <= PW'(NUM_PORTS - 1);
      burst_cnt <= '0;
    end else if ((state_q == IDLE) && grant_found) begin
      cur_port  <= grant_port;
      rr_ptr    <= grant_port;
      burst_cnt <= '0;
    end else if (pop) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
    pop |-> (count_q[cur_port] != '0));
  a_no_write_full: assert property (@(posedge clk) disable iff (!rst)
    fifo_wrreq_out |-> (count_q[enq_port_in] != CW'(FIFO_DEPTH)));

endmodule
